// File: rtl/wishbone_mem_arbiter.sv
// Two-master Wishbone arbiter: round-robin ownership with a per-strobe watchdog
// that terminates a stalled access with an error-pattern acknowledge.
module wishbone_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_m0_we,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic [3:0]  i_m0_sel,
    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    output logic        o_m0_ack,
    output logic [31:0] o_m0_dat,
    output logic        o_m0_int,
    input  logic        i_m1_we,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic [3:0]  i_m1_sel,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    output logic        o_m1_ack,
    output logic [31:0] o_m1_dat,
    output logic        o_m1_int,
    output logic        o_s_we,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic [3:0]  o_s_sel,
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    input  logic        i_s_ack,
    input  logic [31:0] i_s_dat,
    input  logic        i_s_int,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    // state | meaning
    // IDLE  | no owner, slave side driven to zero
    // OWN0  | master 0 owns the slave port
    // OWN1  | master 1 owns the slave port
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        last_owner;
    logic [15:0] wd_cnt;
    logic        fire;

    logic        own0, own1;
    logic        own_cyc, own_stb;
    logic        own_ack;
    logic [31:0] own_dat;
    logic        wd_hit;

    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        o_s_we  = 1'b0;
        o_s_cyc = 1'b0;
        o_s_stb = 1'b0;
        o_s_sel = 4'h0;
        o_s_adr = 32'h0;
        o_s_dat = 32'h0;
        if (own0) begin
            own_cyc = i_m0_cyc;
            own_stb = i_m0_stb;
            o_s_we  = i_m0_we;
            o_s_cyc = i_m0_cyc;
            o_s_stb = i_m0_stb & ~fire;
            o_s_sel = i_m0_sel;
            o_s_adr = i_m0_adr;
            o_s_dat = i_m0_dat;
        end else if (own1) begin
            own_cyc = i_m1_cyc;
            own_stb = i_m1_stb;
            o_s_we  = i_m1_we;
            o_s_cyc = i_m1_cyc;
            o_s_stb = i_m1_stb & ~fire;
            o_s_sel = i_m1_sel;
            o_s_adr = i_m1_adr;
            o_s_dat = i_m1_dat;
        end
    end

    // A slave ack on the last wait cycle beats the watchdog.
    assign wd_hit = own_cyc & own_stb & ~i_s_ack & ~fire & (wd_cnt == WD_LAST);

    // Ack is gated by the owner's cyc so an ack arriving after release is dropped.
    assign own_ack = fire | (own_cyc & i_s_ack);
    assign own_dat = fire ? 32'hFFFF_FFFF : (own_cyc ? i_s_dat : 32'h0);

    assign o_m0_ack  = own0 & own_ack;
    assign o_m1_ack  = own1 & own_ack;
    assign o_m0_dat  = own0 ? own_dat : 32'h0;
    assign o_m1_dat  = own1 ? own_dat : 32'h0;
    assign o_m0_int  = i_s_int;
    assign o_m1_int  = i_s_int;
    assign o_grant   = {own1, own0};
    assign o_timeout = fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            wd_cnt     <= 16'h0;
            fire       <= 1'b0;
        end else begin
            fire <= wd_hit;
            if (fire || wd_hit || !own_cyc || !own_stb || i_s_ack)
                wd_cnt <= 16'h0;
            else
                wd_cnt <= wd_cnt + 16'h1;

            case (state)
                IDLE: begin
                    if (i_m0_cyc && (!i_m1_cyc || last_owner)) begin
                        state      <= OWN0;
                        last_owner <= 1'b0;
                    end else if (i_m1_cyc) begin
                        state      <= OWN1;
                        last_owner <= 1'b1;
                    end
                end
                OWN0:    if (!i_m0_cyc) state <= IDLE;
                OWN1:    if (!i_m1_cyc) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_mem_arbiter.sv
// Directed bench for wishbone_mem_arbiter (TIMEOUT=4): arbitration, forwarding,
// watchdog expiry versus last-moment ack, late ack after release, and reset abort.
module tb_wishbone_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_m0_we, i_m0_cyc, i_m0_stb;
    logic [3:0]  i_m0_sel;
    logic [31:0] i_m0_adr, i_m0_dat;
    logic        o_m0_ack, o_m0_int;
    logic [31:0] o_m0_dat;
    logic        i_m1_we, i_m1_cyc, i_m1_stb;
    logic [3:0]  i_m1_sel;
    logic [31:0] i_m1_adr, i_m1_dat;
    logic        o_m1_ack, o_m1_int;
    logic [31:0] o_m1_dat;
    logic        o_s_we, o_s_cyc, o_s_stb;
    logic [3:0]  o_s_sel;
    logic [31:0] o_s_adr, o_s_dat;
    logic        i_s_ack, i_s_int;
    logic [31:0] i_s_dat;
    logic [1:0]  o_grant;
    logic        o_timeout;

    int n_vec = 0;
    int n_bad = 0;

    wishbone_mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_m0_we(i_m0_we), .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb),
        .i_m0_sel(i_m0_sel), .i_m0_adr(i_m0_adr), .i_m0_dat(i_m0_dat),
        .o_m0_ack(o_m0_ack), .o_m0_dat(o_m0_dat), .o_m0_int(o_m0_int),
        .i_m1_we(i_m1_we), .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb),
        .i_m1_sel(i_m1_sel), .i_m1_adr(i_m1_adr), .i_m1_dat(i_m1_dat),
        .o_m1_ack(o_m1_ack), .o_m1_dat(o_m1_dat), .o_m1_int(o_m1_int),
        .o_s_we(o_s_we), .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb),
        .o_s_sel(o_s_sel), .o_s_adr(o_s_adr), .o_s_dat(o_s_dat),
        .i_s_ack(i_s_ack), .i_s_dat(i_s_dat), .i_s_int(i_s_int),
        .o_grant(o_grant), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] radr [3];
        radr[0] = 32'h10; radr[1] = 32'h14; radr[2] = 32'h18;

        rst = 1'b1;
        i_m0_we = 0; i_m0_cyc = 0; i_m0_stb = 0; i_m0_sel = 4'h0; i_m0_adr = 0; i_m0_dat = 0;
        i_m1_we = 0; i_m1_cyc = 0; i_m1_stb = 0; i_m1_sel = 4'h0; i_m1_adr = 0; i_m1_dat = 0;
        i_s_ack = 0; i_s_dat = 0; i_s_int = 0;
        tick(); tick();
        chk("rst_grant", 32'(o_grant), 32'h0);
        chk("rst_s_cyc", 32'(o_s_cyc), 32'h0);
        chk("rst_timeout", 32'(o_timeout), 32'h0);
        chk("rst_m0_ack", 32'(o_m0_ack), 32'h0);

        // Tie after reset goes to master 0; interrupt fans out in idle.
        rst = 1'b0;
        i_s_int = 1'b1;
        #1;
        chk("int_m0", 32'(o_m0_int), 32'h1);
        chk("int_m1", 32'(o_m1_int), 32'h1);
        i_s_int = 1'b0;
        i_m0_cyc = 1; i_m1_cyc = 1; i_m0_adr = 32'h100; i_m1_adr = 32'h200;
        #1;
        chk("tie_pre_grant", 32'(o_grant), 32'h0);
        tick();
        chk("tie_grant", 32'(o_grant), 32'h1);
        chk("tie_s_cyc", 32'(o_s_cyc), 32'h1);
        i_m0_stb = 1; i_s_ack = 1; i_s_dat = 32'h0000_A5A5;
        #1;
        chk("m0_s_adr", o_s_adr, 32'h100);
        chk("m0_s_stb", 32'(o_s_stb), 32'h1);
        chk("m0_ack", 32'(o_m0_ack), 32'h1);
        chk("m0_dat", o_m0_dat, 32'h0000_A5A5);
        chk("m1_ack_non_owner", 32'(o_m1_ack), 32'h0);
        chk("m1_dat_non_owner", o_m1_dat, 32'h0);
        i_s_ack = 0; i_m0_stb = 0; i_m0_cyc = 0;
        tick();
        chk("gap_grant", 32'(o_grant), 32'h0);
        tick();
        chk("m1_grant", 32'(o_grant), 32'h2);
        chk("m1_s_adr", o_s_adr, 32'h200);

        // m1 holds ownership across three reads while m0 waits.
        i_m0_cyc = 1; i_m0_stb = 1; i_m0_adr = 32'h300;
        for (int k = 0; k < 3; k++) begin
            i_m1_stb = 1; i_m1_adr = radr[k]; i_s_ack = 1; i_s_dat = 32'hD000 + radr[k];
            #1;
            chk("rd_s_adr", o_s_adr, radr[k]);
            chk("rd_m1_dat", o_m1_dat, 32'hD000 + radr[k]);
            chk("rd_m0_ack", 32'(o_m0_ack), 32'h0);
            chk("rd_grant", 32'(o_grant), 32'h2);
            tick();
        end
        i_m1_stb = 0; i_m1_cyc = 0; i_s_ack = 0;
        #1;
        chk("rd_hold_grant", 32'(o_grant), 32'h2);
        tick();
        chk("rd_gap_grant", 32'(o_grant), 32'h0);
        chk("rd_gap_m0_ack", 32'(o_m0_ack), 32'h0);
        tick();
        chk("m0_after_grant", 32'(o_grant), 32'h1);

        // Slave never acks: four wait cycles, then the watchdog answers.
        for (int w = 1; w <= 4; w++) begin
            chk("wd_wait_timeout", 32'(o_timeout), 32'h0);
            chk("wd_wait_ack", 32'(o_m0_ack), 32'h0);
            chk("wd_wait_stb", 32'(o_s_stb), 32'h1);
            tick();
        end
        chk("wd_fire_timeout", 32'(o_timeout), 32'h1);
        chk("wd_fire_ack", 32'(o_m0_ack), 32'h1);
        chk("wd_fire_dat", o_m0_dat, 32'hFFFF_FFFF);
        chk("wd_fire_stb", 32'(o_s_stb), 32'h0);
        chk("wd_fire_m1_ack", 32'(o_m1_ack), 32'h0);
        i_m0_stb = 0;
        tick();
        chk("wd_after_timeout", 32'(o_timeout), 32'h0);
        chk("wd_after_ack", 32'(o_m0_ack), 32'h0);

        // Ack on the fourth wait cycle wins over the watchdog.
        i_m0_stb = 1; i_m0_adr = 32'h40;
        tick(); tick(); tick();
        i_s_ack = 1; i_s_dat = 32'h1234;
        #1;
        chk("race_ack", 32'(o_m0_ack), 32'h1);
        chk("race_dat", o_m0_dat, 32'h1234);
        chk("race_timeout_now", 32'(o_timeout), 32'h0);
        tick();
        i_s_ack = 0; i_m0_stb = 0;
        #1;
        chk("race_timeout_next", 32'(o_timeout), 32'h0);
        chk("race_ack_next", 32'(o_m0_ack), 32'h0);

        // Owner abandons a pending strobe; the late ack goes nowhere.
        i_m0_stb = 1;
        tick();
        i_m0_stb = 0; i_m0_cyc = 0;
        tick();
        i_s_ack = 1; i_s_dat = 32'h5555;
        #1;
        chk("late_grant", 32'(o_grant), 32'h0);
        chk("late_m0_ack", 32'(o_m0_ack), 32'h0);
        chk("late_m1_ack", 32'(o_m1_ack), 32'h0);
        chk("late_m0_dat", o_m0_dat, 32'h0);
        i_s_ack = 0;

        // Reset mid-write aborts; master 0 wins the tie afterwards.
        i_m0_cyc = 1; i_m0_stb = 1; i_m0_we = 1; i_m0_sel = 4'hF;
        i_m0_adr = 32'h20; i_m0_dat = 32'hDEAD;
        tick();
        chk("wr_grant", 32'(o_grant), 32'h1);
        chk("wr_s_we", 32'(o_s_we), 32'h1);
        chk("wr_s_adr", o_s_adr, 32'h20);
        chk("wr_s_dat", o_s_dat, 32'hDEAD);
        chk("wr_s_sel", 32'(o_s_sel), 32'hF);
        i_m1_cyc = 1;
        rst = 1;
        tick();
        chk("rstmid_grant", 32'(o_grant), 32'h0);
        chk("rstmid_s_cyc", 32'(o_s_cyc), 32'h0);
        i_s_ack = 1;
        #1;
        chk("rstmid_m0_ack", 32'(o_m0_ack), 32'h0);
        chk("rstmid_m1_ack", 32'(o_m1_ack), 32'h0);
        i_s_ack = 0;
        rst = 0;
        tick();
        chk("post_rst_tie", 32'(o_grant), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wishbone_mem_arbiter.md
WISHBONE_MEM_ARBITER -- requirements
Module: wishbone_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles without slave ack before the watchdog terminates a strobe; legal range 2..65535.
REQ-002 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Ports i_mN_we, i_mN_cyc, i_mN_stb (N=0,1), input, 1 each: master N write enable, bus-cycle request and strobe.
REQ-005 Ports i_mN_sel, input, 4; i_mN_adr and i_mN_dat, input, 32 each: master N byte select, address and write data.
REQ-006 Ports o_mN_ack, output, 1; o_mN_dat, output, 32; o_mN_int, output, 1: master N acknowledge, read data and interrupt.
REQ-007 Ports o_s_we, o_s_cyc, o_s_stb, output, 1 each; o_s_sel, output, 4; o_s_adr and o_s_dat, output, 32 each: shared slave-side request to the memory interconnect.
REQ-008 Ports i_s_ack, input, 1; i_s_dat, input, 32; i_s_int, input, 1: slave acknowledge, read data and interrupt.
REQ-009 Port o_grant, output, 2: one-hot current owner (bit N = master N); 2'b00 when idle.
REQ-010 Port o_timeout, output, 1: one-cycle pulse when the watchdog fires.

Function
REQ-011 The controller SHALL use a registered FSM with states IDLE, OWN0 and OWN1, plus a 1-bit last_owner register.
REQ-012 In IDLE, on a rising edge, if exactly one i_mN_cyc is high, the FSM SHALL enter OWNN.
REQ-013 In IDLE with both cyc high, the FSM SHALL enter OWN(1-last_owner) (round-robin).
REQ-014 On entry to OWNN, last_owner SHALL be set to N; grant latency from cyc rising to o_s_cyc is one clock.
REQ-015 In OWNN the FSM SHALL hold ownership while i_mN_cyc is high, ignoring the other master.
REQ-016 In OWNN, when i_mN_cyc is sampled low, the FSM SHALL return to IDLE on that edge; the next grant occurs no earlier than the following edge, giving at least one idle cycle between owners.
REQ-017 o_s_* SHALL combinationally equal the owner's i_mN_* signals; in IDLE all o_s_* SHALL be 0.
REQ-018 The owner's o_mN_ack and o_mN_dat SHALL equal i_s_ack and i_s_dat combinationally; for the non-owner, and for both masters in IDLE, they SHALL be 0.
REQ-019 o_m0_int and o_m1_int SHALL both follow i_s_int regardless of ownership.
REQ-020 A 16-bit watchdog counter SHALL increment each cycle the owner has i_mN_stb high and i_s_ack low, and SHALL clear on i_s_ack, on stb low, or in IDLE.
REQ-021 When the counter equals TIMEOUT-1 and i_s_ack is low, on the next cycle the arbiter SHALL: drive o_mN_ack=1 and o_mN_dat=32'hFFFFFFFF to the owner for exactly one cycle, force o_s_stb=0 for that cycle, pulse o_timeout, and clear the counter.
REQ-022 If i_s_ack arrives in the same cycle the counter reaches TIMEOUT-1, the slave ack SHALL win and no timeout SHALL occur.
REQ-023 If the owner drops cyc during a pending strobe, ownership SHALL release per REQ-016, and a late i_s_ack SHALL NOT be forwarded to either master.

Reset
REQ-024 While rst is high at a rising edge: state=IDLE, last_owner=1 (master 0 wins the first tie), counter=0, o_timeout=0, o_grant=2'b00, all o_s_* and o_mN_ack/o_mN_dat=0.
REQ-025 Reset asserted mid-transfer SHALL abort ownership on that edge with no ack issued to either master.

Verification
REQ-026 Reset released, both cyc rise in the same cycle -> o_grant=01 one clock later; m0 drops cyc -> IDLE for one cycle, then o_grant=10.
REQ-027 m1 owns and performs 3 back-to-back reads of 0x10, 0x14, 0x18 while m0 requests -> m0 is not granted until m1 drops cyc; o_m0_ack stays 0 throughout.
REQ-028 TIMEOUT=4, slave never acks -> exactly 4 wait cycles, then o_m0_ack=1 with o_m0_dat=FFFFFFFF for one cycle and o_timeout pulses once.
REQ-029 TIMEOUT=4, i_s_ack arrives on the 4th wait cycle -> slave data forwarded and o_timeout stays 0.
REQ-030 rst asserted during an m0 write to 0x20 -> next cycle o_grant=00 and o_s_cyc=0; after release, a tie grants m0.
